// File: rtl/tag_pkg.sv
// Shared widths, entry layout, FSM states and address field helpers for the
// tag-lookup controller.
package tag_pkg;

   localparam int unsigned TAG_W     = 52;
   localparam int unsigned INDEX_W   = 9;
   localparam int unsigned OFFSET_W  = 3;
   localparam int unsigned ADDR_W    = TAG_W + INDEX_W + OFFSET_W;
   localparam int unsigned ENTRY_W   = TAG_W + 2;
   localparam int unsigned DEPTH     = 512;
   localparam int unsigned VALID_BIT = 53;
   localparam int unsigned DIRTY_BIT = 52;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_CMP,
      ST_MISS,
      ST_WRITE
   } state_e;

   // t_ram entry as stored: {valid, dirty, tag}
   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } entry_t;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W + INDEX_W +: TAG_W];
   endfunction

endpackage

// File: rtl/tag_cmp.sv
// Tag comparator: decides hit and whether the resident entry needs writeback.
module tag_cmp
   import tag_pkg::*;
(
   input  logic [ENTRY_W-1:0] entry,
   input  logic [TAG_W-1:0]   req_tag,
   output logic               hit_c,
   output logic               victim_dirty_c
);

   assign hit_c          = entry[VALID_BIT] && (entry[TAG_W-1:0] == req_tag);
   assign victim_dirty_c = entry[VALID_BIT] && entry[DIRTY_BIT];

endmodule

// File: rtl/tag_ctrl.sv
// Cache tag-lookup controller: invalidation sweep after reset, then
// lookup / miss handoff / entry update against the t_ram tag store.
module tag_ctrl
   import tag_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                req_we,
   output logic                resp_valid,
   output logic                resp_hit,
   output logic                miss_valid,
   output logic [INDEX_W-1:0]  miss_index,
   output logic                miss_victim_dirty,
   output logic [TAG_W-1:0]    miss_victim_tag,
   input  logic                fill_done,
   output logic [INDEX_W-1:0]  ram_addr,
   output logic                ram_wr,
   output logic [ENTRY_W-1:0]  ram_wd,
   input  logic [ENTRY_W-1:0]  ram_rd
);

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               we_q, we_d;
   logic               hit_q, hit_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_hit_q, resp_hit_d;
   logic               miss_valid_q, miss_valid_d;
   logic [INDEX_W-1:0] miss_index_q, miss_index_d;
   logic               miss_dirty_q, miss_dirty_d;
   logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
   logic               ram_wr_q, ram_wr_d;
   entry_t             ram_wd_q, ram_wd_d;
   logic               cmp_hit_c;
   logic               cmp_dirty_c;
   logic               unused_offset_c;

   // line offset plays no part in tag lookup
   assign unused_offset_c = ^req_addr[OFFSET_W-1:0];

   tag_cmp u_cmp (
      .entry          (ram_rd),
      .req_tag        (tag_q),
      .hit_c          (cmp_hit_c),
      .victim_dirty_c (cmp_dirty_c)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_INIT;
         cnt_q        <= '0;
         idx_q        <= '0;
         tag_q        <= '0;
         we_q         <= 1'b0;
         hit_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         miss_valid_q <= 1'b0;
         miss_index_q <= '0;
         miss_dirty_q <= 1'b0;
         miss_tag_q   <= '0;
         ram_wr_q     <= 1'b1;
         ram_wd_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
         we_q         <= we_d;
         hit_q        <= hit_d;
         resp_valid_q <= resp_valid_d;
         resp_hit_q   <= resp_hit_d;
         miss_valid_q <= miss_valid_d;
         miss_index_q <= miss_index_d;
         miss_dirty_q <= miss_dirty_d;
         miss_tag_q   <= miss_tag_d;
         ram_wr_q     <= ram_wr_d;
         ram_wd_q     <= ram_wd_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      tag_d        = tag_q;
      we_d         = we_q;
      hit_d        = hit_q;
      resp_valid_d = 1'b0;
      resp_hit_d   = 1'b0;
      miss_valid_d = miss_valid_q;
      miss_index_d = miss_index_q;
      miss_dirty_d = miss_dirty_q;
      miss_tag_d   = miss_tag_q;
      ram_wr_d     = 1'b0;
      ram_wd_d     = ram_wd_q;
      req_ready    = 1'b0;

      case (state_q)
         ST_INIT: begin
            if (cnt_q == INDEX_W'(DEPTH - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d    = cnt_q + INDEX_W'(1);
               ram_wr_d = 1'b1;
               ram_wd_d = '0;
            end
         end
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               idx_d   = addr_index(req_addr);
               tag_d   = addr_tag(req_addr);
               we_d    = req_we;
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            if (cmp_hit_c) begin
               hit_d = 1'b1;
               // first store to a clean line must mark it dirty in t_ram
               if (we_q && !cmp_dirty_c) begin
                  state_d  = ST_WRITE;
                  ram_wr_d = 1'b1;
                  ram_wd_d = '{valid: 1'b1, dirty: 1'b1, tag: tag_q};
               end else begin
                  state_d      = ST_IDLE;
                  resp_valid_d = 1'b1;
                  resp_hit_d   = 1'b1;
               end
            end else begin
               hit_d        = 1'b0;
               state_d      = ST_MISS;
               miss_valid_d = 1'b1;
               miss_index_d = idx_q;
               miss_dirty_d = cmp_dirty_c;
               miss_tag_d   = ram_rd[TAG_W-1:0];
            end
         end
         ST_MISS: begin
            if (fill_done) begin
               miss_valid_d = 1'b0;
               hit_d        = 1'b0;
               state_d      = ST_WRITE;
               ram_wr_d     = 1'b1;
               ram_wd_d     = '{valid: 1'b1, dirty: we_q, tag: tag_q};
            end
         end
         ST_WRITE: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_hit_d   = hit_q;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // IDLE presents the incoming index so the entry is ready in CMP
   always_comb begin
      case (state_q)
         ST_IDLE: ram_addr = addr_index(req_addr);
         ST_INIT: ram_addr = cnt_q;
         default: ram_addr = idx_q;
      endcase
   end

   assign resp_valid        = resp_valid_q;
   assign resp_hit          = resp_hit_q;
   assign miss_valid        = miss_valid_q;
   assign miss_index        = miss_index_q;
   assign miss_victim_dirty = miss_dirty_q;
   assign miss_victim_tag   = miss_tag_q;
   assign ram_wr            = ram_wr_q;
   assign ram_wd            = ram_wd_q;

endmodule

// File: doc/tag_ctrl.md
Name: tag_ctrl

Overview:
- Cache tag-lookup controller; the initiator side of the t_ram tag store (54-bit entries, 512 sets).
- Accepts CPU access requests, reads the set's tag entry, and compares it to the request tag.
- Reports hit or miss, hands miss/victim information to the refill logic, and writes updated entries back to t_ram.
- After reset it invalidates every entry with a sweep of the tag RAM.

Parameters:
- TAG_W, 52, tag field width.
- INDEX_W, 9, set index width (t_ram address).
- OFFSET_W, 3, line offset width (ignored by this block).
- DEPTH, 512, number of sets (must equal 2**INDEX_W).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  controller can accept a request this cycle.
- req_addr  in  TAG_W+INDEX_W+OFFSET_W  byte address {tag,index,offset}.
- req_we  in  1  request is a store.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = serviced after refill.
- miss_valid  out  1  refill required; held until fill_done.
- miss_index  out  INDEX_W  set being refilled.
- miss_victim_dirty  out  1  victim entry valid and dirty (writeback needed).
- miss_victim_tag  out  TAG_W  victim tag.
- fill_done  in  1  refill complete; sampled only in MISS.
- ram_addr  out  INDEX_W  to t_ram.
- ram_wr  out  1  to t_ram.
- ram_wd  out  TAG_W+2  to t_ram, entry {valid,dirty,tag}.
- ram_rd  in  TAG_W+2  from t_ram; synchronous read, valid the cycle after ram_addr is presented.

Behaviour:
- Entry layout: bit 53 valid, bit 52 dirty, bits 51:0 tag.
- States: INIT, IDLE, CMP, MISS, WRITE.
- reset=0 at a clock edge forces the following, regardless of current state:
  - state INIT, sweep counter 0;
  - resp_valid, resp_hit, miss_valid, miss_victim_dirty = 0; miss_index, miss_victim_tag = 0;
  - latched request discarded; no pending write is completed.
- INIT:
  - ram_wr=1, ram_addr=counter, ram_wd=0; counter increments each cycle.
  - After writing DEPTH-1, go to IDLE. Sweep is 512 cycles; req_ready=0 throughout.
- IDLE:
  - req_ready=1; ram_addr = req_addr index (combinational); ram_wr=0.
  - On req_valid: latch addr/we, go to CMP.
- CMP (ram_rd holds the entry): hit = valid & (tag == latched tag).
  - hit & (!we | dirty): resp_valid=1, resp_hit=1 next cycle; go to IDLE. Read hit latency is 2 cycles from acceptance.
  - hit & we & !dirty: go to WRITE with ram_wd={1,1,tag}; hit flag kept.
  - miss: go to MISS, register miss_index, miss_victim_tag, and miss_victim_dirty=valid&dirty. miss_valid=1 from the next cycle.
- MISS:
  - miss_valid and miss_* held stable.
  - On fill_done: miss_valid=0, go to WRITE with ram_wd={1,we,req_tag}; hit flag cleared.
- WRITE:
  - ram_wr=1 for exactly one cycle at the latched index.
  - Next cycle: IDLE with resp_valid=1, resp_hit=hit flag.
- req_ready=1 only in IDLE. A new request may be accepted in the same cycle resp_valid pulses (back-to-back).
- resp_valid is never asserted together with miss_valid.
- fill_done outside MISS: ignored.
- fill_done in the first MISS cycle: legal; WRITE follows next cycle.
- ram_wr is never asserted in IDLE, CMP or MISS.
- All outputs except ram_addr (IDLE mux) and req_ready are registered.

Decomposition:
- Package tag_pkg: ENTRY_W=TAG_W+2, VALID_BIT=53, DIRTY_BIT=52, state encoding enum, address field slice helpers.
- One sub-module, tag_cmp: entry + request tag -> hit, victim_dirty. Combinational, instantiated in tag_ctrl.
- The sweep counter stays inline.

Test Plan:
- Release reset -> 512 consecutive cycles of ram_wr=1, wd=0, addresses 0..511. req_ready rises on the following cycle.
- Read 0x0000_0000_0000_1008 (index 1) after sweep -> miss_valid=1, miss_index=1, victim_dirty=0, victim_tag=0. fill_done -> one write of {1,0,tag} to addr 1, then resp_valid=1, resp_hit=0.
- Repeat the same read -> resp_valid with resp_hit=1 exactly 2 cycles after acceptance; no ram_wr.
- Store to the same address -> write of {1,1,tag} to addr 1, resp_hit=1. A second store hits without any ram_wr.
- Load, same index, different tag -> miss_victim_dirty=1, miss_victim_tag = the old tag.
- Assert reset while in MISS -> miss_valid=0 next cycle, INIT sweep restarts at address 0, no response is ever issued for the aborted request.
